// File: rtl/game_pkg.sv
// Shared types and sizes for the invaders game controller.
package game_pkg;

  localparam int unsigned NUM_INVADERS = 10;
  localparam int unsigned FIELD_WIDTH  = 20;
  localparam int unsigned SCORE_W      = 8;
  localparam int unsigned LEVEL_W      = 3;
  localparam int unsigned IDX_W        = 5;
  localparam int unsigned LINE_W       = 4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_PLAY     = 3'd2,
    S_HIT      = 3'd3,
    S_LEVEL_UP = 3'd4,
    S_OVER     = 3'd5
  } state_t;

  // Score increment that sticks at the maximum value.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (v == '1) ? v : v + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/lsb_finder.sv
// Priority encoder: index of the lowest set bit of the formation field.
module lsb_finder
  import game_pkg::*;
(
  input  logic [FIELD_WIDTH-1:0] vec,
  output logic [IDX_W-1:0]       index,
  output logic                   found
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    index = '0;
    found = 1'b0;
    for (int i = int'(FIELD_WIDTH) - 1; i >= 0; i--) begin
      if (vec[i]) begin
        index = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/game_controller.sv
// Game sequencing: load/play/hit/level-up/over, alive tracking, score and level.
module game_controller
  import game_pkg::*;
#(
  parameter int unsigned BOTTOM_LINE = 12,
  parameter int unsigned MAX_LEVEL   = 7
) (
  input  logic                    clk_36MHz,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    bullet_valid,
  input  logic [IDX_W-1:0]        bullet_x,
  input  logic [LINE_W-1:0]       bullet_y,
  input  logic [FIELD_WIDTH-1:0]  invaders_array,
  input  logic [LINE_W-1:0]       invaders_line,
  output logic                    formation_reset,
  output logic [NUM_INVADERS-1:0] alive_mask,
  output logic                    hit,
  output logic                    bullet_kill,
  output logic [LEVEL_W-1:0]      level,
  output logic [SCORE_W-1:0]      score,
  output logic                    game_over,
  output logic [2:0]              state
);

  state_t           state_q;
  logic [IDX_W-1:0] offset;
  logic             found;
  logic [IDX_W-1:0] kdiff;
  logic [3:0]       kidx;
  logic             collision;
  logic             at_bottom;

  lsb_finder u_lsb_finder (
    .vec   (invaders_array),
    .index (offset),
    .found (found)
  );

  assign kdiff = bullet_x - offset;
  assign kidx  = kdiff[3:0];

  // Bullet overlaps a live invader of the formation on the formation's line.
  assign collision = (state_q == S_PLAY) && found && bullet_valid &&
                     (bullet_y == invaders_line) &&
                     (bullet_x < IDX_W'(FIELD_WIDTH)) &&
                     (bullet_x >= offset) &&
                     (kdiff <= IDX_W'(NUM_INVADERS - 1)) &&
                     alive_mask[kidx];

  assign at_bottom = (invaders_line >= LINE_W'(BOTTOM_LINE));

  assign formation_reset = (state_q != S_LOAD);
  assign state           = state_q;

  always_ff @(posedge clk_36MHz or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      alive_mask  <= '0;
      level       <= '0;
      score       <= '0;
      hit         <= 1'b0;
      bullet_kill <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      hit         <= 1'b0;
      bullet_kill <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_LOAD;
            level      <= '0;
            score      <= '0;
            alive_mask <= '1;
          end
        end
        S_LOAD: state_q <= S_PLAY;
        S_PLAY: begin
          // Reaching the bottom wins over any simultaneous hit.
          if (at_bottom) begin
            state_q   <= S_OVER;
            game_over <= 1'b1;
          end else if (collision) begin
            state_q          <= S_HIT;
            alive_mask[kidx] <= 1'b0;
            score            <= sat_inc(score);
            hit              <= 1'b1;
            bullet_kill      <= 1'b1;
          end
        end
        S_HIT: state_q <= (alive_mask == '0) ? S_LEVEL_UP : S_PLAY;
        S_LEVEL_UP: begin
          state_q    <= S_LOAD;
          alive_mask <= '1;
          level      <= (level < LEVEL_W'(MAX_LEVEL)) ? level + LEVEL_W'(1)
                                                      : LEVEL_W'(MAX_LEVEL);
        end
        S_OVER: begin
          if (start) begin
            state_q    <= S_LOAD;
            game_over  <= 1'b0;
            level      <= '0;
            score      <= '0;
            alive_mask <= '1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with immediate-assertion checks.
module tb_game_controller;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_LOAD = 3'd1, ST_PLAY = 3'd2,
                         ST_HIT  = 3'd3, ST_LVL  = 3'd4, ST_OVER = 3'd5;

  logic        clk_36MHz = 1'b0;
  logic        reset;
  logic        start;
  logic        bullet_valid;
  logic [4:0]  bullet_x;
  logic [3:0]  bullet_y;
  logic [19:0] invaders_array;
  logic [3:0]  invaders_line;
  logic        formation_reset;
  logic [9:0]  alive_mask;
  logic        hit;
  logic        bullet_kill;
  logic [2:0]  level;
  logic [7:0]  score;
  logic        game_over;
  logic [2:0]  state;

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0] exp_alive;
  logic [7:0] exp_score;

  game_controller #(.BOTTOM_LINE(12), .MAX_LEVEL(7)) dut (
    .clk_36MHz       (clk_36MHz),
    .reset           (reset),
    .start           (start),
    .bullet_valid    (bullet_valid),
    .bullet_x        (bullet_x),
    .bullet_y        (bullet_y),
    .invaders_array  (invaders_array),
    .invaders_line   (invaders_line),
    .formation_reset (formation_reset),
    .alive_mask      (alive_mask),
    .hit             (hit),
    .bullet_kill     (bullet_kill),
    .level           (level),
    .score           (score),
    .game_over       (game_over),
    .state           (state)
  );

  always #5 clk_36MHz = ~clk_36MHz;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_36MHz);
    #1;
  endtask

  task automatic fire(input logic [4:0] x, input logic [3:0] y);
    bullet_valid = 1'b1;
    bullet_x     = x;
    bullet_y     = y;
    tick();
    bullet_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; bullet_valid = 1'b0; bullet_x = '0; bullet_y = '0;
    invaders_array = 20'h003FF; invaders_line = 4'd1;
    #3;
    check("rst_state", 32'(state), 32'(ST_IDLE));
    check("rst_alive", 32'(alive_mask), 32'h0);
    check("rst_level", 32'(level), 32'h0);
    check("rst_score", 32'(score), 32'h0);
    check("rst_hit", 32'({hit, bullet_kill}), 32'h0);
    check("rst_over", 32'(game_over), 32'h0);
    check("rst_freset", 32'(formation_reset), 32'h1);
    tick(); tick();
    check("rst_hold_state", 32'(state), 32'(ST_IDLE));
    reset = 1'b1;
    tick();
    check("idle_no_start", 32'(state), 32'(ST_IDLE));

    // Start a game: one LOAD cycle with the formation held in reset.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("load_state", 32'(state), 32'(ST_LOAD));
    check("load_freset", 32'(formation_reset), 32'h0);
    check("load_alive", 32'(alive_mask), 32'h3FF);
    tick();
    check("play_state", 32'(state), 32'(ST_PLAY));
    check("play_freset", 32'(formation_reset), 32'h1);
    check("play_alive", 32'(alive_mask), 32'h3FF);
    check("play_level", 32'(level), 32'h0);
    check("play_score", 32'(score), 32'h0);

    // First hit on invader 3.
    fire(5'd3, 4'd1);
    check("hit1_state", 32'(state), 32'(ST_HIT));
    check("hit1_pulse", 32'({hit, bullet_kill}), 32'h3);
    check("hit1_alive", 32'(alive_mask), 32'h3F7);
    check("hit1_score", 32'(score), 32'h1);
    tick();
    check("hit1_back", 32'(state), 32'(ST_PLAY));
    check("hit1_pulse_end", 32'({hit, bullet_kill}), 32'h0);

    // Same spot again: invader 3 is already dead.
    fire(5'd3, 4'd1);
    check("dead_state", 32'(state), 32'(ST_PLAY));
    check("dead_hit", 32'(hit), 32'h0);
    check("dead_score", 32'(score), 32'h1);

    // Wrong line.
    fire(5'd0, 4'd2);
    check("line_miss", 32'(state), 32'(ST_PLAY));

    // Empty field never collides.
    invaders_array = 20'h00000;
    fire(5'd0, 4'd1);
    check("empty_miss", 32'(state), 32'(ST_PLAY));

    // Offset 19: x=20 is off the field.
    invaders_array = 20'h80000;
    fire(5'd20, 4'd1);
    check("x20_miss", 32'(state), 32'(ST_PLAY));

    // Offset 10: a column left of the formation misses.
    invaders_array = 20'hFFC00;
    fire(5'd9, 4'd1);
    check("left_miss", 32'(state), 32'(ST_PLAY));

    // Sweep x=10..19; invader 3 already dead, remaining nine clear the wave.
    exp_alive = 10'h3F7;
    exp_score = 8'd1;
    for (int x = 10; x < 20; x++) begin
      fire(5'(x), 4'd1);
      if (exp_alive[x-10]) begin
        exp_alive[x-10] = 1'b0;
        exp_score++;
        check("sweep_hit_state", 32'(state), 32'(ST_HIT));
        check("sweep_pulse", 32'({hit, bullet_kill}), 32'h3);
        check("sweep_alive", 32'(alive_mask), 32'(exp_alive));
        check("sweep_score", 32'(score), 32'(exp_score));
        tick();
        check("sweep_after", 32'(state), (exp_alive == 10'h0) ? 32'(ST_LVL) : 32'(ST_PLAY));
      end else begin
        check("sweep_dead", 32'(state), 32'(ST_PLAY));
      end
    end
    tick();
    check("lvl_load_state", 32'(state), 32'(ST_LOAD));
    check("lvl_level", 32'(level), 32'h1);
    check("lvl_alive", 32'(alive_mask), 32'h3FF);
    check("lvl_score", 32'(score), 32'd10);
    check("lvl_freset", 32'(formation_reset), 32'h0);
    tick();
    check("lvl_play", 32'(state), 32'(ST_PLAY));

    // Bottom reached together with a valid collision: game over wins.
    invaders_array = 20'h003FF;
    invaders_line  = 4'd12;
    fire(5'd0, 4'd12);
    check("over_state", 32'(state), 32'(ST_OVER));
    check("over_flag", 32'(game_over), 32'h1);
    check("over_score", 32'(score), 32'd10);
    check("over_hit", 32'(hit), 32'h0);
    tick();
    check("over_hold", 32'(state), 32'(ST_OVER));
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_state", 32'(state), 32'(ST_LOAD));
    check("restart_level", 32'(level), 32'h0);
    check("restart_score", 32'(score), 32'h0);
    check("restart_over", 32'(game_over), 32'h0);
    invaders_line = 4'd1;
    tick();
    check("restart_play", 32'(state), 32'(ST_PLAY));

    // Asynchronous reset in the middle of a HIT cycle.
    fire(5'd0, 4'd1);
    check("pre_rst_hit", 32'(state), 32'(ST_HIT));
    #2;
    reset = 1'b0;
    #1;
    check("async_state", 32'(state), 32'(ST_IDLE));
    check("async_alive", 32'(alive_mask), 32'h0);
    check("async_pulse", 32'({hit, bullet_kill}), 32'h0);
    check("async_score", 32'(score), 32'h0);
    check("async_level", 32'(level), 32'h0);
    check("async_freset", 32'(formation_reset), 32'h1);
    tick();
    reset = 1'b1;
    tick();
    check("post_rst_idle", 32'(state), 32'(ST_IDLE));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 SHALL have parameter BOTTOM_LINE, default 12: formation line at which the game is lost.
REQ-002 SHALL have parameter MAX_LEVEL, default 7: level saturation value.
REQ-003 SHALL have port clk_36MHz, input, 1: single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: player start request, level-sensitive, sampled each clock.
REQ-006 SHALL have ports bullet_valid (input, 1), bullet_x (input, 5) and bullet_y (input, 4): player bullet presence, column and line.
REQ-007 SHALL have ports invaders_array (input, 20) and invaders_line (input, 4): current formation position from the formation mover.
REQ-008 SHALL have port formation_reset, output, 1: active-low restart strobe driven into the formation mover's reset.
REQ-009 SHALL have port alive_mask, output, 10: bit k = 1 means invader k (k = 0 at lowest set column) is alive.
REQ-010 SHALL have ports hit (output, 1) and bullet_kill (output, 1): one-cycle pulses on a confirmed hit.
REQ-011 SHALL have ports level (output, 3), score (output, 8), game_over (output, 1) and state (output, 3).

Function
REQ-012 SHALL implement FSM states IDLE, LOAD, PLAY, HIT, LEVEL_UP and OVER, with state output = encoding 0..5 in that order.
REQ-013 SHALL move IDLE->LOAD when start=1, and SHALL clear level and score to 0 on that transition.
REQ-014 SHALL hold LOAD for exactly 1 cycle, drive formation_reset=0 during it, set alive_mask=10'h3FF, then move to PLAY.
REQ-015 SHALL compute offset as the index of the lowest set bit of invaders_array, and SHALL treat an all-zero invaders_array as no collision.
REQ-016 SHALL detect a collision in PLAY only, requiring all of: bullet_valid=1; bullet_y==invaders_line; bullet_x<20; bullet_x>=offset; k=bullet_x-offset<=9; alive_mask[k]=1.
REQ-017 SHALL, on a collision, at the next edge enter HIT, clear alive_mask[k], increment score saturating at 255, and assert hit=1 and bullet_kill=1 for that single HIT cycle.
REQ-018 SHALL leave HIT after 1 cycle, going to LEVEL_UP if alive_mask==0 and to PLAY otherwise.
REQ-019 SHALL hold LEVEL_UP for 1 cycle, set level=min(level+1, MAX_LEVEL), then go to LOAD; score SHALL be retained.
REQ-020 SHALL move PLAY->OVER when invaders_line>=BOTTOM_LINE, and this SHALL take priority over a collision in the same cycle (no hit, score unchanged).
REQ-021 SHALL drive game_over=1 exactly while in OVER, and SHALL move OVER->LOAD on start=1, clearing level and score on that transition.
REQ-022 SHALL ignore bullets in all states other than PLAY, and SHALL NOT fire hit or bullet_kill outside HIT.
REQ-023 SHALL register all outputs, except formation_reset which SHALL be decoded from state LOAD.
REQ-024 SHALL hold formation_reset=1 in every state other than LOAD.

Reset
REQ-025 SHALL, on reset=0 at any time including mid-game, asynchronously force state=IDLE, alive_mask=0, level=0, score=0, hit=0, bullet_kill=0, game_over=0 and formation_reset=1.
REQ-026 SHALL start its first transition on the first rising edge after reset deasserts.

Structure
REQ-027 SHALL take the state encoding, NUM_INVADERS=10, FIELD_WIDTH=20 and the score width from shared package game_pkg.
REQ-028 SHALL place the 20-bit lowest-set-bit priority encoder (index plus found flag) in sub-module lsb_finder.

Verification
REQ-029 Reset then start=1 -> state IDLE->LOAD, formation_reset=0 for one cycle, then PLAY with alive_mask=3FF, level=0, score=0.
REQ-030 In PLAY: invaders_array=0x003FF, line=1, bullet valid at x=3, y=1 -> next cycle hit=bullet_kill=1, alive_mask=3F7, score=1; one cycle later state=PLAY.
REQ-031 Repeat the REQ-030 bullet at x=3 -> no hit, because alive_mask[3]=0.
REQ-032 With invaders_array=0x0FFC00 (offset 10), hit each of x=10..19 -> after the tenth HIT, LEVEL_UP, then level=1 and LOAD, alive_mask=3FF, score=10.
REQ-033 invaders_line=12 in the same cycle as a valid collision -> state OVER, game_over=1, score unchanged; start=1 -> LOAD with level=0, score=0.
REQ-034 reset=0 asserted mid-HIT, between clock edges -> all outputs take reset values immediately, without waiting for a clock edge.
